// File: rtl/sc_fifo_wr_arbiter.sv
// sc_fifo_wr_arbiter: round-robin burst-locking arbiter sharing one FIFO write port among N producers
module sc_fifo_wr_arbiter #(
    parameter int N         = 4,
    parameter int DW        = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N-1:0]              req_valid,
    input  logic [N*DW-1:0]           req_data,
    output logic [N-1:0]              req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_write,
    output logic [DW-1:0]             fifo_din,
    output logic                      grant_vld,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_id
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = $clog2(BURST_LEN + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] grant_id_q, grant_id_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;
    logic [IW-1:0] pick, idx;
    logic          found, sel_valid, accept, last_beat, release_w;

    // first valid requester scanning upward from the round-robin pointer, wrapping mod N
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr_q;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(rr_ptr_q) + k) % N);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // a beat moves only while bursting, the holder is valid, the FIFO has room and reset is low
    always_comb begin
        sel_valid = req_valid[grant_id_q];
        accept    = (state_q == BURST) && sel_valid && !fifo_full && !rst;
        last_beat = beat_cnt_q == BW'(BURST_LEN - 1);
        release_w = (state_q == BURST) && (!sel_valid || (accept && last_beat));
    end

    // next-state: grant from IDLE, count beats in BURST, release on valid drop or burst end
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        if (state_q == IDLE) begin
            if (found) begin
                state_d    = BURST;
                grant_id_d = pick;
            end
        end else if (release_w) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
            rr_ptr_d   = (grant_id_q == IW'(N - 1)) ? '0 : grant_id_q + 1'b1;
        end else if (accept) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // steer the granted requester onto the FIFO write port; write is never raised while full
    always_comb begin
        req_ready  = accept ? (N'(1) << grant_id_q) : '0;
        fifo_write = accept;
        fifo_din   = rst ? '0 : req_data[grant_id_q*DW +: DW];
        grant_vld  = state_q == BURST;
        grant_id   = grant_id_q;
    end
endmodule
